// File: rtl/missile_pkg.sv
// Shared missile types: heading encoding (also used by tank and renderer),
// controller states and default screen dimensions.
package missile_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    EXPLODE,
    COOLDOWN
  } mstate_t;

  localparam int DEFAULT_SCREEN_W = 640;
  localparam int DEFAULT_SCREEN_H = 480;

endpackage

// File: rtl/frame_counter.sv
// Frame-tick counter with synchronous clear and a terminal-count flag;
// shared by the explosion and reload timers.
module frame_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             tick,
  input  logic [WIDTH-1:0] last,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (tick)
      count <= count + 1'b1;
  end

  assign terminal = (count == last);

endmodule

// File: rtl/missile_move_ctrl.sv
// Missile position/heading controller: launch, per-frame motion, off-screen
// retire and timed explosion. Define MISSILE_COOLDOWN_EN for a reload lockout.
module missile_move_ctrl
  import missile_pkg::*;
#(
  parameter int SPEED           = 4,
  parameter int SCREEN_W        = DEFAULT_SCREEN_W,
  parameter int SCREEN_H        = DEFAULT_SCREEN_H,
  parameter int MISSILE_W       = 8,
  parameter int MISSILE_H       = 8,
  parameter int EXPLODE_FRAMES  = 8,
  parameter int COOLDOWN_FRAMES = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] tankX,
  input  logic [10:0] tankY,
  input  logic [1:0]  tankDir,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  dir,
  output logic        active,
  output logic        exploding
);

  localparam int MAX_FRAMES = (EXPLODE_FRAMES > COOLDOWN_FRAMES) ? EXPLODE_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;
  localparam logic [CNT_W-1:0] EXPLODE_LAST  = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [11:0] SPEED12 = 12'(SPEED);
  localparam logic [11:0] LIM_X   = 12'(SCREEN_W);
  localparam logic [11:0] LIM_Y   = 12'(SCREEN_H);
  localparam logic [11:0] MW12    = 12'(MISSILE_W);
  localparam logic [11:0] MH12    = 12'(MISSILE_H);

`ifdef MISSILE_COOLDOWN_EN
  localparam mstate_t RETIRE_STATE = COOLDOWN;
`else
  localparam mstate_t RETIRE_STATE = IDLE;
`endif

  mstate_t     state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  dir_t        dir_q, dir_d;
  logic        hit_q, hit_d;
  logic        active_q, exploding_q;
  logic [11:0] x_ext, y_ext;
  logic        off_screen;
  logic        timer_state, timer_tick, timer_clear, timer_done;
  logic [CNT_W-1:0] timer_last;

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  // Checked against the current position so a retiring missile never wraps.
  always_comb begin
    off_screen = 1'b0;
    case (dir_q)
      DIR_UP:    off_screen = (y_ext < SPEED12);
      DIR_LEFT:  off_screen = (x_ext < SPEED12);
      DIR_RIGHT: off_screen = (x_ext + SPEED12 + MW12 > LIM_X);
      DIR_DOWN:  off_screen = (y_ext + SPEED12 + MH12 > LIM_Y);
      default:   off_screen = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          x_d     = tankX;
          y_d     = tankY;
          dir_d   = dir_t'(tankDir);
          hit_d   = 1'b0;
          state_d = FLYING;
        end
      end
      FLYING: begin
        if (collision || hit_q) begin
          hit_d   = 1'b0;
          state_d = EXPLODE;
        end else if (startOfFrame) begin
          if (off_screen) begin
            state_d = RETIRE_STATE;
          end else begin
            case (dir_q)
              DIR_UP:    y_d = 11'(y_ext - SPEED12);
              DIR_DOWN:  y_d = 11'(y_ext + SPEED12);
              DIR_LEFT:  x_d = 11'(x_ext - SPEED12);
              DIR_RIGHT: x_d = 11'(x_ext + SPEED12);
              default:   x_d = x_q;
            endcase
          end
        end
      end
      EXPLODE: begin
        if (startOfFrame && timer_done)
          state_d = RETIRE_STATE;
      end
`ifdef MISSILE_COOLDOWN_EN
      COOLDOWN: begin
        if (startOfFrame && timer_done)
          state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Timer restarts from zero on every state change.
  assign timer_state = (state_q == EXPLODE) || (state_q == COOLDOWN);
  assign timer_tick  = startOfFrame && timer_state;
  assign timer_clear = (state_d != state_q) || !timer_state;
  assign timer_last  = (state_q == COOLDOWN) ? COOLDOWN_LAST : EXPLODE_LAST;

  frame_counter #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (timer_clear),
    .tick     (timer_tick),
    .last     (timer_last),
    .terminal (timer_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= DIR_UP;
      hit_q       <= 1'b0;
      active_q    <= 1'b0;
      exploding_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      hit_q       <= hit_d;
      active_q    <= (state_d == FLYING);
      exploding_q <= (state_d == EXPLODE);
    end
  end

  assign topLeftX  = x_q;
  assign topLeftY  = y_q;
  assign dir       = dir_q;
  assign active    = active_q;
  assign exploding = exploding_q;

endmodule

// File: tb/tb_missile_move_ctrl.sv
// Directed self-checking bench for missile_move_ctrl; expectations switch
// on MISSILE_COOLDOWN_EN to match the reload lockout.
module tb_missile_move_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        fire;
  logic [10:0] tankX;
  logic [10:0] tankY;
  logic [1:0]  tankDir;
  logic        collision;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  dir;
  logic        active;
  logic        exploding;

  int compareCount = 0;
  int failCount    = 0;

  missile_move_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .fire         (fire),
    .tankX        (tankX),
    .tankY        (tankY),
    .tankDir      (tankDir),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .dir          (dir),
    .active       (active),
    .exploding    (exploding)
  );

  always #5 clk = ~clk;

  // One active edge, then settle at the falling edge for driving/sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic f, input logic [10:0] x, input logic [10:0] y,
                               input logic [1:0] d, input logic c, input logic sof);
    fire         = f;
    tankX        = x;
    tankY        = y;
    tankDir      = d;
    collision    = c;
    startOfFrame = sof;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] ex, input logic [10:0] ey,
                             input logic [1:0] ed, input logic ea, input logic ee);
    logic [24:0] observed;
    logic [24:0] expected;
    observed = {topLeftX, topLeftY, dir, active, exploding};
    expected = {ex, ey, ed, ea, ee};
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed x=%0d y=%0d dir=%0d act=%0b exp=%0b, expected x=%0d y=%0d dir=%0d act=%0b exp=%0b",
             tag, topLeftX, topLeftY, dir, active, exploding, ex, ey, ed, ea, ee);
    end
  endtask

  // After a retire or explosion the cooldown build needs 16 frames before relaunch.
  task automatic recover();
`ifdef MISSILE_COOLDOWN_EN
    for (int i = 0; i < 16; i++) frame();
`endif
  endtask

  initial begin
    resetN = 1'b0;
    applyStimulus(1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset", 11'd0, 11'd0, 2'd0, 1'b0, 1'b0);
    resetN = 1'b1;
    tick();

    // collision outside FLYING is ignored
    collision = 1'b1;
    tick();
    collision = 1'b0;
    checkOutput("idle_collision", 11'd0, 11'd0, 2'd0, 1'b0, 1'b0);

    // launch right, 3 frames
    applyStimulus(1'b1, 11'd100, 11'd200, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 11'd300, 11'd300, 2'b10, 1'b0, 1'b0);
    checkOutput("launch", 11'd100, 11'd200, 2'b01, 1'b1, 1'b0);
    frame(); frame(); frame();
    checkOutput("fly3", 11'd112, 11'd200, 2'b01, 1'b1, 1'b0);

    // mid-frame collision, explosion runs 8 frames
    collision = 1'b1;
    tick();
    collision = 1'b0;
    checkOutput("explode_enter", 11'd112, 11'd200, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) frame();
    checkOutput("explode_7", 11'd112, 11'd200, 2'b01, 1'b0, 1'b1);
    frame();
    checkOutput("explode_done", 11'd112, 11'd200, 2'b01, 1'b0, 1'b0);
    recover();

    // up from Y=6: one move, then retire holding Y=2
    applyStimulus(1'b1, 11'd50, 11'd6, 2'b00, 1'b0, 1'b0);
    tick();
    fire = 1'b0;
    frame();
    checkOutput("up_move", 11'd50, 11'd2, 2'b00, 1'b1, 1'b0);
    frame();
    checkOutput("up_retire", 11'd50, 11'd2, 2'b00, 1'b0, 1'b0);
    recover();

    // right from X=628: 628+12=640 is on screen, 632+12 is not
    applyStimulus(1'b1, 11'd628, 11'd100, 2'b01, 1'b0, 1'b0);
    tick();
    fire = 1'b0;
    frame();
    checkOutput("right_edge_move", 11'd632, 11'd100, 2'b01, 1'b1, 1'b0);
    frame();
    checkOutput("right_retire", 11'd632, 11'd100, 2'b01, 1'b0, 1'b0);
    recover();

    // left from X=3 retires on first frame
    applyStimulus(1'b1, 11'd3, 11'd40, 2'b11, 1'b0, 1'b0);
    tick();
    fire = 1'b0;
    frame();
    checkOutput("left_retire", 11'd3, 11'd40, 2'b11, 1'b0, 1'b0);
    recover();

    // down from Y=468: moves to 472, then retires
    applyStimulus(1'b1, 11'd20, 11'd468, 2'b10, 1'b0, 1'b0);
    tick();
    fire = 1'b0;
    frame();
    checkOutput("down_edge_move", 11'd20, 11'd472, 2'b10, 1'b1, 1'b0);
    frame();
    checkOutput("down_retire", 11'd20, 11'd472, 2'b10, 1'b0, 1'b0);
    recover();

    // simultaneous collision+SOF with fire held high throughout
    applyStimulus(1'b1, 11'd200, 11'd200, 2'b10, 1'b0, 1'b0);
    tick();
    tankX = 11'd10; tankY = 11'd50; tankDir = 2'b11;
    checkOutput("hold_launch", 11'd200, 11'd200, 2'b10, 1'b1, 1'b0);
    collision = 1'b1; startOfFrame = 1'b1;
    tick();
    collision = 1'b0; startOfFrame = 1'b0;
    checkOutput("coll_sof", 11'd200, 11'd200, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) frame();
    checkOutput("hold_explode", 11'd200, 11'd200, 2'b10, 1'b0, 1'b1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checkOutput("hold_explode_done", 11'd200, 11'd200, 2'b10, 1'b0, 1'b0);
`ifdef MISSILE_COOLDOWN_EN
    tick();
    checkOutput("cooldown_block", 11'd200, 11'd200, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) frame();
    checkOutput("cooldown_15", 11'd200, 11'd200, 2'b10, 1'b0, 1'b0);
    frame();
`endif
    tick();
    fire = 1'b0;
    checkOutput("relaunch", 11'd10, 11'd50, 2'b11, 1'b1, 1'b0);

    // reset mid-explosion clears everything asynchronously
    collision = 1'b1;
    tick();
    collision = 1'b0;
    frame(); frame(); frame();
    checkOutput("pre_reset_explode", 11'd10, 11'd50, 2'b11, 1'b0, 1'b1);
    resetN = 1'b0;
    #1;
    checkOutput("async_reset", 11'd0, 11'd0, 2'd0, 1'b0, 1'b0);
    tick();
    resetN = 1'b1;
    frame(); frame();
    checkOutput("post_reset_idle", 11'd0, 11'd0, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
